adaptive_filter: RTL and testbench

Streaming first-order filter on signed fixed-point samples. It has two modes, selected by `ctrl`:
- `ctrl`=0: differentiator (first difference).
- `ctrl`=1: integrator (running sum).
It sits in the sample datapath between an AXI-Stream-like producer and consumer. There is no backpressure: one sample per valid cycle, with a fixed latency of 1 clock.

---
 rtl/adaptive_filter.sv | 76 +++++++
 tb/tb_adaptive_filter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/adaptive_filter.sv
// First-order streaming filter on signed fixed-point samples: first difference
// (ctrl=0) or saturating running sum (ctrl=1), with one clock of latency.
module adaptive_filter #(
  parameter int WORDLENGTH        = 14,
  parameter int FRACTIONAL_LENGTH = 6
) (
  input  logic                                                       clk,
  input  logic                                                       srst,
  input  logic                                                       ctrl,
  input  logic signed [WORDLENGTH-FRACTIONAL_LENGTH-1:-FRACTIONAL_LENGTH] s_tdata,
  input  logic                                                       s_tvalid,
  output logic signed [WORDLENGTH-FRACTIONAL_LENGTH-1:-FRACTIONAL_LENGTH] m_tdata,
  output logic                                                       m_tvalid
);

  localparam int W = WORDLENGTH;

  // Clamp a W+1 bit two's-complement result back into W bits.
  function automatic logic [W-1:0] sat(input logic [W:0] v);
    if (v[W] != v[W-1]) begin
      if (v[W]) begin
        return {1'b1, {(W-1){1'b0}}};
      end else begin
        return {1'b0, {(W-1){1'b1}}};
      end
    end else begin
      return v[W-1:0];
    end
  endfunction

  logic [W-1:0] x_s;
  logic [W-1:0] diff_s;
  logic [W-1:0] integ_s;
  logic [W-1:0] x_prev_q, x_prev_d;
  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] m_tdata_q, m_tdata_d;
  logic         m_tvalid_q, m_tvalid_d;

  // Both histories advance on every accepted sample so ctrl can switch freely.
  always_comb begin
    x_s        = s_tdata;
    diff_s     = sat({x_s[W-1], x_s} - {x_prev_q[W-1], x_prev_q});
    integ_s    = sat({acc_q[W-1], acc_q} + {x_s[W-1], x_s});
    x_prev_d   = x_prev_q;
    acc_d      = acc_q;
    m_tdata_d  = m_tdata_q;
    m_tvalid_d = 1'b0;
    if (s_tvalid) begin
      x_prev_d   = x_s;
      acc_d      = integ_s;
      m_tdata_d  = ctrl ? integ_s : diff_s;
      m_tvalid_d = 1'b1;
    end else begin
      m_tvalid_d = 1'b0;
    end
  end

  // State and output registers; reset wins over any in-flight sample.
  always_ff @(posedge clk) begin
    if (srst) begin
      x_prev_q   <= {W{1'b0}};
      acc_q      <= {W{1'b0}};
      m_tdata_q  <= {W{1'b0}};
      m_tvalid_q <= 1'b0;
    end else begin
      x_prev_q   <= x_prev_d;
      acc_q      <= acc_d;
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
    end
  end

  assign m_tdata  = m_tdata_q;
  assign m_tvalid = m_tvalid_q;

endmodule

// File: tb/tb_adaptive_filter.sv
// Bench for adaptive_filter: directed test-plan sequences then random traffic,
// all checked against an integer reference model of the filter rules.
module tb_adaptive_filter;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic        ctrl = 1'b0;
  logic [13:0] s_tdata = 14'h0000;
  logic        s_tvalid = 1'b0;
  logic [13:0] m_tdata;
  logic        m_tvalid;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, held as plain integers.
  int          ref_xprev = 0;
  int          ref_acc   = 0;
  logic [13:0] ref_data  = 14'h0000;
  logic        ref_valid = 1'b0;

  adaptive_filter #(.WORDLENGTH(14), .FRACTIONAL_LENGTH(6)) dut (
    .clk      (clk),
    .srst     (srst),
    .ctrl     (ctrl),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > 8191) return 8191;
    if (v < -8192) return -8192;
    return v;
  endfunction

  function automatic int to_int(input logic [13:0] d);
    return int'($signed(d));
  endfunction

  // Apply one cycle of inputs, advance the model with the edge, then compare.
  task automatic step(input logic r, input logic v, input logic c, input logic [13:0] d);
    int x, diff, integ;
    srst = r; s_tvalid = v; ctrl = c; s_tdata = d;
    @(posedge clk);
    if (r) begin
      ref_xprev = 0; ref_acc = 0; ref_data = 14'h0000; ref_valid = 1'b0;
    end else if (v) begin
      x     = to_int(d);
      diff  = clamp(x - ref_xprev);
      integ = clamp(ref_acc + x);
      ref_xprev = x;
      ref_acc   = integ;
      ref_data  = c ? 14'(integ) : 14'(diff);
      ref_valid = 1'b1;
    end else begin
      ref_valid = 1'b0;
    end
    #1;
    chk("m_tvalid", {31'd0, m_tvalid}, {31'd0, ref_valid});
    chk("m_tdata", {18'd0, m_tdata}, {18'd0, ref_data});
  endtask

  logic [13:0] rd;

  initial begin
    // Reset held with valid data present.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 14'h0040);
    chk("reset_data", {18'd0, m_tdata}, 32'h0000_0000);

    // Differentiator ramp.
    step(1'b0, 1'b1, 1'b0, 14'h0040);
    chk("first_after_reset", {18'd0, m_tdata}, 32'h0000_0040);
    step(1'b0, 1'b1, 1'b0, 14'h0080);
    step(1'b0, 1'b1, 1'b0, 14'h00C0);
    step(1'b0, 1'b1, 1'b0, 14'h0100);
    chk("ramp_diff", {18'd0, m_tdata}, 32'h0000_0040);

    // Integrator constant then down-steps.
    step(1'b1, 1'b0, 1'b0, 14'h0000);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 14'h0040);
    chk("integ_up", {18'd0, m_tdata}, 32'h0000_0100);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 14'h3FC0);
    chk("integ_down", {18'd0, m_tdata}, 32'h0000_0040);

    // Saturation in both modes.
    step(1'b1, 1'b0, 1'b0, 14'h0000);
    step(1'b0, 1'b1, 1'b0, 14'h1FFF);
    step(1'b0, 1'b1, 1'b0, 14'h2000);
    chk("sat_diff_min", {18'd0, m_tdata}, 32'h0000_2000);
    step(1'b1, 1'b0, 1'b0, 14'h0000);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 14'h1000);
    chk("sat_integ_max", {18'd0, m_tdata}, 32'h0000_1FFF);

    // Valid gaps hold data.
    step(1'b1, 1'b0, 1'b0, 14'h0000);
    step(1'b0, 1'b1, 1'b0, 14'h0040);
    step(1'b0, 1'b0, 1'b0, 14'h1234);
    chk("gap_hold", {18'd0, m_tdata}, 32'h0000_0040);
    step(1'b0, 1'b0, 1'b0, 14'h0ABC);
    step(1'b0, 1'b1, 1'b0, 14'h00C0);
    chk("gap_diff", {18'd0, m_tdata}, 32'h0000_0080);

    // Mode switch, then mid-stream reset.
    step(1'b1, 1'b0, 1'b0, 14'h0000);
    step(1'b0, 1'b1, 1'b1, 14'h0040);
    step(1'b0, 1'b1, 1'b1, 14'h0040);
    step(1'b0, 1'b1, 1'b0, 14'h0100);
    chk("mode_switch", {18'd0, m_tdata}, 32'h0000_00C0);
    step(1'b1, 1'b1, 1'b1, 14'h0100);
    step(1'b0, 1'b1, 1'b1, 14'h0040);
    chk("acc_cleared", {18'd0, m_tdata}, 32'h0000_0040);

    // Random traffic, with large magnitudes often enough to hit saturation.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) rd = $urandom_range(1) ? 14'h1F00 + 14'($urandom_range(255))
                                                         : 14'h2000 + 14'($urandom_range(255));
      else rd = 14'($urandom);
      step($urandom_range(40) == 0, $urandom_range(3) != 0, 1'($urandom), rd);
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
